// File: rtl/esc_halfduplex_uart.sv
// esc_halfduplex_uart: one-wire half-duplex ESC UART bridge with a TX FIFO, guard/hold OE framing and echo-free RX.
// Define ESC_UART_STATS_EN to add saturating tx byte and rx framing-error counters.
module esc_halfduplex_uart #(
    parameter int CLK_FREQ_HZ = 72_000_000,
    parameter int BAUD        = 19200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        en_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_frame_err_o,
    output logic        serial_tx_o,
    output logic        serial_oe_o,
    input  logic        serial_rx_i,
`ifdef ESC_UART_STATS_EN
    output logic [15:0] tx_count_o,
    output logic [15:0] rx_err_count_o,
`endif
    output logic        busy_o
);
    localparam int T  = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int CW = (T > 1) ? $clog2(T) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] T_LAST = CW'(T - 1);
    localparam logic [CW-1:0] T_HALF = CW'(T / 2 - 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_GUARD = 3'd1, S_START = 3'd2,
                           S_DATA = 3'd3, S_STOP = 3'd4, S_HOLD = 3'd5;
    localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [2:0]    tx_state_q, tx_state_d, tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic          rx_prev_q, rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
    logic          empty, full, wr, pop, tx_tick, rx_tick, rx_en, rx_fall;

    assign empty          = count_q == '0;
    assign full           = count_q == (AW+1)'(FIFO_DEPTH);
    assign tx_ready_o     = wb_rst_ni & en_i & ~full;
    assign wr             = tx_valid_i & tx_ready_o;
    assign tx_tick        = tx_cnt_q == T_LAST;
    assign rx_tick        = rx_cnt_q == T_LAST;
    assign rx_en          = en_i & (tx_state_q == S_IDLE);
    assign rx_fall        = rx_prev_q & ~serial_rx_i;
    assign serial_oe_o    = tx_state_q != S_IDLE;
    assign serial_tx_o    = (tx_state_q == S_START) ? 1'b0 : (tx_state_q == S_DATA) ? tx_sh_q[0] : 1'b1;
    assign busy_o         = serial_oe_o | ~empty;
    assign rx_data_o      = rx_data_q;
    assign rx_valid_o     = rx_valid_q;
    assign rx_frame_err_o = rx_err_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        pop        = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (!empty && rx_state_q == R_IDLE && !rx_fall) tx_state_d = S_GUARD;
            end
            S_GUARD: if (tx_tick) begin
                tx_state_d = S_START;
                pop        = 1'b1;
            end
            S_START: if (tx_tick) begin
                tx_state_d = S_DATA;
                tx_bit_d   = '0;
            end
            S_DATA: if (tx_tick) begin
                tx_sh_d    = tx_sh_q >> 1;
                tx_bit_d   = tx_bit_q + 1'b1;
                tx_state_d = (tx_bit_q == 3'd7) ? S_STOP : S_DATA;
            end
            S_STOP, S_HOLD: if (tx_tick) begin
                pop        = ~empty;
                tx_state_d = !empty ? S_START : (tx_state_q == S_STOP) ? S_HOLD : S_IDLE;
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (pop) tx_sh_d = mem_q[rd_ptr_q];
        if (!en_i) begin
            tx_state_d = S_IDLE;
            tx_cnt_d   = '0;
            pop        = 1'b0;
        end
    end

    // RX samples from the start-bit midpoint, then every T; it is held idle whenever we drive the line
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d   = '0;
                rx_state_d = rx_fall ? R_START : R_IDLE;
            end
            R_START: if (rx_cnt_q == T_HALF) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = serial_rx_i ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_tick) begin
                rx_cnt_d   = '0;
                rx_sh_d    = {serial_rx_i, rx_sh_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                rx_state_d = (rx_bit_q == 3'd7) ? R_STOP : R_DATA;
            end
            default: if (rx_tick) begin
                rx_state_d = R_IDLE;
                rx_valid_d = serial_rx_i;
                rx_err_d   = ~serial_rx_i;
                rx_data_d  = serial_rx_i ? rx_sh_q : rx_data_q;
            end
        endcase
        if (!rx_en) begin
            rx_state_d = R_IDLE;
            rx_cnt_d   = '0;
            rx_valid_d = 1'b0;
            rx_err_d   = 1'b0;
            rx_data_d  = rx_data_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr) mem_q[wr_ptr_q] <= tx_data_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_prev_q  <= 1'b1;
        end else begin
            if (!en_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + AW'(wr);
                rd_ptr_q <= rd_ptr_q + AW'(pop);
                count_q  <= count_q + (AW+1)'(wr) - (AW+1)'(pop);
            end
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            rx_prev_q  <= serial_rx_i;
        end
    end

`ifdef ESC_UART_STATS_EN
    logic [15:0] tx_count_q, rx_err_count_q;
    assign tx_count_o     = tx_count_q;
    assign rx_err_count_o = rx_err_count_q;
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tx_count_q     <= '0;
            rx_err_count_q <= '0;
        end else begin
            if (en_i && tx_state_q == S_STOP && tx_tick && tx_count_q != 16'hFFFF) tx_count_q <= tx_count_q + 1'b1;
            if (rx_err_d && rx_err_count_q != 16'hFFFF) rx_err_count_q <= rx_err_count_q + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_esc_halfduplex_uart.sv
// tb_esc_halfduplex_uart: bench for esc_halfduplex_uart at a reduced bit period (T=16 clocks).
// The line is modelled as a mux: the DUT's own TX when OE is high, otherwise the bench's RX driver.
module tb_esc_halfduplex_uart;
    localparam int T = 16;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, tx_valid = 1'b0, rx_drv = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, rx_valid, ferr, stx, soe, busy, srx;
    logic [7:0] rx_data;
`ifdef ESC_UART_STATS_EN
    logic [15:0] txc, rxec;
`endif

    int total = 0, bad = 0;
    int good_frames = 0, oe_rises = 0, oe_len = 0, guard_len = 0;
    int rxv_cnt = 0, rxe_cnt = 0, both_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         ev;
        int         ee;
    } rx_vec_t;

    assign srx = soe ? stx : rx_drv;
    always #5 clk = ~clk;

    esc_halfduplex_uart #(.CLK_FREQ_HZ(160), .BAUD(10), .FIFO_DEPTH(16)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .en_i(en),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_frame_err_o(ferr),
        .serial_tx_o(stx), .serial_oe_o(soe), .serial_rx_i(srx),
`ifdef ESC_UART_STATS_EN
        .tx_count_o(txc), .rx_err_count_o(rxec),
`endif
        .busy_o(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b, output logic ok);
        @(negedge clk);
        ok = tx_ready;
        tx_data = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        if (ok) exp_q.push_back(b);
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (T) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (T) @(negedge clk);
        end
        rx_drv = stop;
        repeat (T) @(negedge clk);
        rx_drv = 1'b1;
        repeat (T) @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy || soe) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n < 20000, 1);
        repeat (T) @(negedge clk);
    endtask

    // Line monitor: decodes frames while OE is high and scores them against the expected queue
    initial begin : tx_mon
        logic [7:0] b;
        logic p, lost, stp;
        p = 1'b1;
        forever begin
            @(negedge clk);
            if (soe && p && !stx) begin
                repeat (T / 2 - 1) @(negedge clk);
                lost = !soe;
                for (int i = 0; i < 8; i++) begin
                    repeat (T) @(negedge clk);
                    b[i] = stx;
                    lost |= !soe;
                end
                repeat (T) @(negedge clk);
                stp = stx;
                lost |= !soe;
                if (!lost) begin
                    good_frames++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_byte unexpected act=%0h exp=none", b);
                    end else chk("tx_byte", b, exp_q.pop_front());
                    chk("tx_stop", stp, 1);
                end
            end
            p = stx;
        end
    end

    initial begin : oe_mon
        int len, g;
        logic seen;
        len = 0; g = 0; seen = 1'b0;
        forever begin
            @(negedge clk);
            if (soe) begin
                if (len == 0) begin
                    oe_rises++;
                    g = 0;
                    seen = 1'b0;
                end
                len++;
                if (!seen && stx) g++;
                else seen = 1'b1;
            end else begin
                if (len != 0) begin
                    oe_len = len;
                    guard_len = g;
                end
                len = 0;
            end
        end
    end

    initial begin : pulse_mon
        forever begin
            @(negedge clk);
            if (rx_valid) rxv_cnt++;
            if (ferr) rxe_cnt++;
            if (rx_valid && ferr) both_cnt++;
        end
    end

    initial begin
        rx_vec_t vec[5];
        int v0, e0, r0, f0, nacc, n, err_exp;
        logic ok;
        logic [7:0] last_good;
        vec[0] = '{8'h5A, 1'b1, 1, 0};
        vec[1] = '{8'h00, 1'b1, 1, 0};
        vec[2] = '{8'hFF, 1'b1, 1, 0};
        vec[3] = '{8'h81, 1'b0, 0, 1};
        vec[4] = '{8'hC3, 1'b1, 1, 0};
        err_exp = 0;
        last_good = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_oe", soe, 0);
        chk("rst_tx", stx, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_ferr", ferr, 0);

        // Release and write on the very first clock
        r0 = oe_rises;
        f0 = good_frames;
        rst_n = 1'b1;
        #1 chk("ready_after_rst", tx_ready, 1);
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        exp_q.push_back(8'hA5);
        wait_idle("single_idle");
        chk("single_guard", guard_len, T);
        chk("single_oe_len", oe_len, 12 * T);
        chk("single_oe_rises", oe_rises - r0, 1);
        chk("single_frames", good_frames - f0, 1);

        r0 = oe_rises;
        f0 = good_frames;
        put(8'h30, ok);
        put(8'h31, ok);
        put(8'h32, ok);
        wait_idle("burst_idle");
        chk("burst_oe_rises", oe_rises - r0, 1);
        chk("burst_oe_len", oe_len, 32 * T);
        chk("burst_guard", guard_len, T);
        chk("burst_frames", good_frames - f0, 3);

        v0 = rxv_cnt;
        e0 = rxe_cnt;
        put(8'hFF, ok);
        wait_idle("echo_idle");
        chk("echo_valid", rxv_cnt - v0, 0);
        chk("echo_ferr", rxe_cnt - e0, 0);

        for (int i = 0; i < 5; i++) begin
            v0 = rxv_cnt;
            e0 = rxe_cnt;
            drive_rx(vec[i].d, vec[i].stop);
            if (vec[i].ev != 0) last_good = vec[i].d;
            err_exp += vec[i].ee;
            chk($sformatf("rx_valid_%0d", i), rxv_cnt - v0, vec[i].ev);
            chk($sformatf("rx_ferr_%0d", i), rxe_cnt - e0, vec[i].ee);
            chk($sformatf("rx_data_%0d", i), rx_data, last_good);
        end

        v0 = rxv_cnt;
        e0 = rxe_cnt;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (T / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12 * T) @(negedge clk);
        chk("glitch_valid", rxv_cnt - v0, 0);
        chk("glitch_ferr", rxe_cnt - e0, 0);

        // TX request arriving mid-RX must wait for the RX byte
        v0 = rxv_cnt;
        fork
            drive_rx(8'h3C, 1'b1);
            begin
                repeat (3 * T) @(negedge clk);
                put(8'h77, ok);
                repeat (T) @(negedge clk);
                chk("rxblock_oe", soe, 0);
                chk("rxblock_busy", busy, 1);
            end
        join
        chk("rxblock_rx_valid", rxv_cnt - v0, 1);
        chk("rxblock_rx_data", rx_data, 8'h3C);
        wait_idle("rxblock_idle");

        v0 = rxv_cnt;
        f0 = good_frames;
        r0 = oe_rises;
        nacc = 0;
        fork
            drive_rx(8'h11, 1'b1);
            begin
                repeat (T) @(negedge clk);
                for (int i = 0; i < 17; i++) begin
                    put(8'(8'h40 + i), ok);
                    if (i < 16) nacc += int'(ok);
                    else chk("full_17th_ready", ok, 0);
                end
            end
        join
        chk("full_accepted", nacc, 16);
        chk("full_rx_data", rx_data, 8'h11);
        wait_idle("full_idle");
        chk("full_frames", good_frames - f0, 16);
        chk("full_oe_rises", oe_rises - r0, 1);

        f0 = good_frames;
        for (int i = 0; i < 4; i++) put(8'(8'h81 + i), ok);
        n = 0;
        while (good_frames == f0 && n < 20 * T) begin
            @(negedge clk);
            n++;
        end
        chk("abort_first_frame", n < 20 * T, 1);
        repeat (3 * T) @(negedge clk);
        en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_oe", soe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_tx", stx, 1);
        chk("abort_frames", good_frames - f0, 1);
`ifdef ESC_UART_STATS_EN
        chk("abort_tx_count", txc, good_frames);
`endif
        repeat (12 * T) @(negedge clk);
        en = 1'b1;
        put(8'hE7, ok);
        wait_idle("recover_idle");

        chk("queue_empty", exp_q.size(), 0);
        chk("never_both", both_cnt, 0);
`ifdef ESC_UART_STATS_EN
        chk("stats_tx_count", txc, good_frames);
        chk("stats_rx_err", rxec, err_exp);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
